// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcode encoding (common
// with the ALU), instruction-cycle phases and datapath widths.
package cpu_pkg;

  localparam int OPCODE_W = 3;
  localparam int DATA_W   = 8;

  localparam logic [OPCODE_W-1:0] HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] AND = 3'd3;
  localparam logic [OPCODE_W-1:0] XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] STO = 3'd6;
  localparam logic [OPCODE_W-1:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Instruction-cycle sequencer: an 8-phase counter plus a sticky halted flag,
// with control strobes decoded combinationally from phase, opcode and zero.
//
// state      | meaning
// INST_ADDR  | PC drives the address bus
// INST_FETCH | read instruction from memory
// INST_LOAD  | load instruction register
// IDLE       | instruction register settles; opcode stable from here on
// OP_ADDR    | bump PC; HLT freezes the sequencer here
// OP_FETCH   | read operand for ALU instructions
// ALU_OP     | ALU works; SKZ skip, JMP load, STO drives bus
// STORE      | result to accumulator, jump target to PC, or bus to memory
module cpu_controller
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                halt,
  output logic                ld_pc,
  output logic                data_e,
  output logic                ld_ac,
  output logic                wr
);

  phase_t phase, phase_nxt;
  logic   halted, halted_nxt;
  logic   aluop;

  assign aluop = is_aluop(opcode);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      halted <= halted_nxt;
    end
  end

  always_comb begin
    phase_nxt  = phase_t'(phase + 3'd1);
    halted_nxt = halted;
    sel        = 1'b0;
    rd         = 1'b0;
    ld_ir      = 1'b0;
    inc_pc     = 1'b0;
    halt       = 1'b0;
    ld_pc      = 1'b0;
    data_e     = 1'b0;
    ld_ac      = 1'b0;
    wr         = 1'b0;

    if (halted) begin
      phase_nxt = phase;
      halt      = 1'b1;
    end else begin
      case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          // PC still advances on HLT so it ends up pointing past the halt
          inc_pc = 1'b1;
          if (opcode == HLT) begin
            halt       = 1'b1;
            halted_nxt = 1'b1;
            phase_nxt  = OP_ADDR;
          end
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: expected strobe vectors are queued as
// each cycle's stimulus is applied and checked mid-cycle on the falling edge.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  logic [2:0] m_phase  = 3'd0;
  logic       m_halted = 1'b0;

  cpu_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference vector {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}
  function automatic logic [8:0] model_out(input logic [2:0] ph, input logic hd,
                                           input logic [2:0] op, input logic z);
    logic alu;
    logic [8:0] v;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    v = 9'b0;
    if (hd) return 9'b000010000;
    case (ph)
      3'd0: v = 9'b100000000;
      3'd1: v = 9'b110000000;
      3'd2: v = 9'b111000000;
      3'd3: v = 9'b111000000;
      3'd4: v = (op == 3'd0) ? 9'b000110000 : 9'b000100000;
      3'd5: v = alu ? 9'b010000000 : 9'b000000000;
      3'd6: begin
        if (alu) v[7] = 1'b1;
        if (op == 3'd1 && z) v[5] = 1'b1;
        if (op == 3'd7) v[3] = 1'b1;
        if (op == 3'd6) v[2] = 1'b1;
      end
      default: begin
        if (alu) v = 9'b010000010;
        if (op == 3'd7) v = 9'b000001000;
        if (op == 3'd6) v = 9'b000000101;
      end
    endcase
    return v;
  endfunction

  // One clock cycle: apply stimulus, queue the expectation, check at negedge,
  // then advance the bench's own phase model at the rising edge.
  task automatic run_cycle(input logic r, input logic [2:0] op, input logic z,
                           input logic do_chk, input logic use_ovr, input logic [8:0] ovr);
    logic [8:0] got, e;
    rst = r; opcode = op; zero = z;
    if (do_chk) exp_q.push_back(use_ovr ? ovr : model_out(m_phase, m_halted, op, z));
    @(negedge clk);
    got = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
    if (do_chk) begin
      e = exp_q.pop_front();
      check("strobes", got, e);
      check("phase", {6'b0, dut.phase}, {6'b0, m_phase});
      check("wr_ldac_excl", {8'b0, wr & ld_ac}, 9'b0);
      if (m_phase < 3'd6) check("wr_ldpc_early", {7'b0, wr, ld_pc}, 9'b0);
    end
    @(posedge clk);
    if (r) begin
      m_phase = 3'd0; m_halted = 1'b0;
    end else if (m_halted) begin
    end else if (m_phase == 3'd4 && op == 3'd0) begin
      m_halted = 1'b1;
    end else begin
      m_phase = m_phase + 3'd1;
    end
    #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, op, z, 1'b1, 1'b0, 9'b0);
  endtask

  logic [8:0] add_vec [8];

  initial begin
    add_vec[0] = 9'b100000000; add_vec[1] = 9'b110000000;
    add_vec[2] = 9'b111000000; add_vec[3] = 9'b111000000;
    add_vec[4] = 9'b000100000; add_vec[5] = 9'b010000000;
    add_vec[6] = 9'b010000000; add_vec[7] = 9'b010000010;

    @(posedge clk); #1;
    // Reset from unknown state; second reset cycle is checkable
    run_cycle(1'b1, ADD, 1'b0, 1'b0, 1'b0, 9'b0);
    run_cycle(1'b1, ADD, 1'b0, 1'b1, 1'b1, 9'b100000000);

    for (int i = 0; i < 8; i++) run_cycle(1'b0, ADD, 1'b0, 1'b1, 1'b1, add_vec[i]);

    run_instr(STO, 1'b0);
    run_instr(SKZ, 1'b1);
    run_instr(SKZ, 1'b0);
    run_instr(JMP, 1'b0);
    run_instr(AND, 1'b1);
    run_instr(XOR, 1'b0);
    run_instr(LDA, 1'b1);
    run_instr(STO, 1'b1);
    run_instr(JMP, 1'b1);

    // zero toggling freely: decode must follow the live value
    for (int i = 0; i < 24; i++)
      run_cycle(1'b0, SKZ, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 9'b0);

    // reset mid-instruction
    for (int i = 0; i < 6; i++) run_cycle(1'b0, ADD, 1'b0, 1'b1, 1'b0, 9'b0);
    run_cycle(1'b1, ADD, 1'b0, 1'b1, 1'b0, 9'b0);
    run_instr(XOR, 1'b1);

    // HLT: 4 fetch phases, OP_ADDR, then frozen for 20 cycles
    for (int i = 0; i < 4; i++) run_cycle(1'b0, HLT, 1'b0, 1'b1, 1'b0, 9'b0);
    run_cycle(1'b0, HLT, 1'b0, 1'b1, 1'b1, 9'b000110000);
    for (int i = 0; i < 20; i++)
      run_cycle(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 9'b000010000);
    run_cycle(1'b1, HLT, 1'b0, 1'b1, 1'b1, 9'b000010000);
    run_cycle(1'b0, HLT, 1'b0, 1'b1, 1'b1, 9'b100000000);
    run_cycle(1'b0, HLT, 1'b0, 1'b1, 1'b1, 9'b110000000);
    run_instr(ADD, 1'b0);

    check("queue_drained", 9'(exp_q.size()), 9'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
